// File: rtl/toi2s_pkg.sv
// Shared types for the amplifier power sequencer.
// Holds the state encoding and the amp register init table.
package toi2s_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWRUP     = 3'd1,
    ST_CFG       = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_RUN       = 3'd4,
    ST_SHUTDOWN  = 3'd5,
    ST_FAULT     = 3'd6
  } seq_state_e;

  localparam int NUM_CFG = 4;
  localparam int IDX_W   = $clog2(NUM_CFG);

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

  function automatic cfg_entry_t cfg_entry(
    input logic [IDX_W-1:0] idx
  );
    cfg_entry_t e;
    case (idx)
      2'd0:    e = '{addr: 8'h02, data: 8'h00};
      2'd1:    e = '{addr: 8'h03, data: 8'h1A};
      2'd2:    e = '{addr: 8'h04, data: 8'h30};
      default: e = '{addr: 8'h05, data: 8'h08};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/amp_seq_timer.sv
// Loadable down-counter for settle and mute delays.
// o_last flags the final count so callers leave on time.
module amp_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/amp_seq_ctrl.sv
// Amplifier power/config/unmute sequencer.
// Define AMP_SEQ_RETRY_EN to retry NACKed writes up to 3 times.
module amp_seq_ctrl
  import toi2s_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int UNMUTE_CYCLES = 256,
  parameter int MUTE_CYCLES   = 64
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       ena,
  input  logic       audio_lock,
  output logic       cfg_req,
  output logic [7:0] cfg_addr,
  output logic [7:0] cfg_data,
  input  logic       cfg_ack,
  input  logic       cfg_nack,
  output logic       amp_nenable,
  output logic       amp_nmute,
  output logic [2:0] seq_state,
  output logic       fault
);

  localparam int TMAX = (SETTLE_CYCLES > MUTE_CYCLES)
                      ? SETTLE_CYCLES : MUTE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int LW = $clog2(UNMUTE_CYCLES + 1);

  seq_state_e       r_state;
  seq_state_e       w_next;
  logic             r_req;
  logic [IDX_W-1:0] r_idx;
  logic [LW-1:0]    r_lock_cnt;
  logic             w_ack;
  logic             w_nack;
  logic             w_last_idx;
  logic             w_lock_hit;
  logic             w_retry_ok;
  logic             w_tmr_load;
  logic [TW-1:0]    w_tmr_val;
  logic             w_tmr_dec;
  logic             w_tmr_zero;
  logic             w_tmr_last;
  logic             w_tmr_done;
  cfg_entry_t       w_entry;

  // Simultaneous ack+nack counts as a NACK.
  assign w_nack     = r_req & cfg_nack;
  assign w_ack      = r_req & cfg_ack & ~cfg_nack;
  assign w_last_idx = (r_idx == IDX_W'(NUM_CFG - 1));
  assign w_lock_hit = audio_lock &&
    (({1'b0, r_lock_cnt} + (LW+1)'(1)) >= (LW+1)'(UNMUTE_CYCLES));
  assign w_tmr_done = w_tmr_zero | w_tmr_last;

`ifdef AMP_SEQ_RETRY_EN
  logic [1:0] r_retry;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_retry <= '0;
    end else if (r_state != ST_CFG || w_ack) begin
      r_retry <= '0;
    end else if (w_nack) begin
      r_retry <= r_retry + 2'd1;
    end
  end

  assign w_retry_ok = (r_retry != 2'd3);
`else
  assign w_retry_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ena) w_next = ST_PWRUP;
      end
      ST_PWRUP: begin
        if (!ena)           w_next = ST_SHUTDOWN;
        else if (w_tmr_done) w_next = ST_CFG;
      end
      ST_CFG: begin
        if (r_req) begin
          if (w_nack) begin
            if (!w_retry_ok) w_next = ST_FAULT;
            else if (!ena)   w_next = ST_SHUTDOWN;
          end else if (w_ack) begin
            if (!ena)           w_next = ST_SHUTDOWN;
            else if (w_last_idx) w_next = ST_WAIT_LOCK;
          end
        end else if (!ena) begin
          w_next = ST_SHUTDOWN;
        end
      end
      ST_WAIT_LOCK: begin
        if (!ena)           w_next = ST_SHUTDOWN;
        else if (w_lock_hit) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (!ena)             w_next = ST_SHUTDOWN;
        else if (!audio_lock) w_next = ST_WAIT_LOCK;
      end
      ST_SHUTDOWN: begin
        if (w_tmr_done) w_next = ST_IDLE;
      end
      ST_FAULT: begin
        if (!ena) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    amp_nenable = 1'b0;
    amp_nmute   = 1'b0;
    fault       = 1'b0;
    case (r_state)
      ST_IDLE:  amp_nenable = 1'b1;
      ST_RUN:   amp_nmute   = 1'b1;
      ST_FAULT: begin
        amp_nenable = 1'b1;
        fault       = 1'b1;
      end
      default: ;
    endcase
  end

  assign seq_state = r_state;
  assign w_entry   = cfg_entry(r_idx);
  assign cfg_req   = r_req;
  assign cfg_addr  = r_req ? w_entry.addr : 8'h00;
  assign cfg_data  = r_req ? w_entry.data : 8'h00;

  // Request drops after each response; gap cycle precedes the next one.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_req <= 1'b0;
      r_idx <= '0;
    end else if (r_state == ST_PWRUP) begin
      r_req <= (w_next == ST_CFG);
      r_idx <= '0;
    end else if (r_state == ST_CFG) begin
      if (r_req) begin
        if (w_ack) begin
          r_req <= 1'b0;
          r_idx <= r_idx + IDX_W'(1);
        end else if (w_nack) begin
          r_req <= 1'b0;
        end
      end else if (w_next == ST_CFG) begin
        r_req <= 1'b1;
      end
    end else begin
      r_req <= 1'b0;
      r_idx <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_lock_cnt <= '0;
    end else if (r_state == ST_WAIT_LOCK && audio_lock) begin
      if (r_lock_cnt != LW'(UNMUTE_CYCLES))
        r_lock_cnt <= r_lock_cnt + LW'(1);
    end else begin
      r_lock_cnt <= '0;
    end
  end

  assign w_tmr_load = (r_state == ST_IDLE && w_next == ST_PWRUP) ||
                      (r_state != ST_SHUTDOWN &&
                       w_next == ST_SHUTDOWN);
  assign w_tmr_val  = (w_next == ST_PWRUP) ? TW'(SETTLE_CYCLES)
                                           : TW'(MUTE_CYCLES);
  assign w_tmr_dec  = (r_state == ST_PWRUP) ||
                      (r_state == ST_SHUTDOWN);

  amp_seq_timer #(
    .W(TW)
  ) u_timer (
    .clk    (clk),
    .resetb (resetb),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .i_dec  (w_tmr_dec),
    .o_zero (w_tmr_zero),
    .o_last (w_tmr_last)
  );

endmodule

// File: tb/tb_amp_seq_ctrl.sv
// Bench for amp_seq_ctrl: config writes checked by a scoreboard,
// sequencing timing checked inline against hand-computed values.
module tb_amp_seq_ctrl;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       ena = 1'b0;
  logic       audio_lock = 1'b0;
  logic       cfg_req;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_ack = 1'b0;
  logic       cfg_nack = 1'b0;
  logic       amp_nenable;
  logic       amp_nmute;
  logic [2:0] seq_state;
  logic       fault;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic        prev_req = 1'b0;

  amp_seq_ctrl #(
    .SETTLE_CYCLES(8),
    .UNMUTE_CYCLES(4),
    .MUTE_CYCLES  (4)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .ena        (ena),
    .audio_lock (audio_lock),
    .cfg_req    (cfg_req),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_ack    (cfg_ack),
    .cfg_nack   (cfg_nack),
    .amp_nenable(amp_nenable),
    .amp_nmute  (amp_nmute),
    .seq_state  (seq_state),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every new write request pops one expectation.
  always @(negedge clk) begin
    if (cfg_req && !prev_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cfg_write unexpected got %h/%h want none",
                 cfg_addr, cfg_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({cfg_addr, cfg_data} !== e) begin
          errors++;
          $display("FAIL cfg_write got %h/%h want %h/%h",
                   cfg_addr, cfg_data, e[15:8], e[7:0]);
        end
      end
    end
    prev_req = cfg_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_reset();
    ena      = 1'b0;
    cfg_ack  = 1'b0;
    cfg_nack = 1'b0;
    resetb   = 1'b0;
    tick();
    resetb = 1'b1;
  endtask

  // Raise ena and count cycles from enable-low to first request.
  task automatic power_up(input string nm);
    int n;
    ena = 1'b1;
    tick();
    chk({nm, "_nenable_low"}, int'(amp_nenable), 0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (cfg_req) begin
        n = i;
        break;
      end
    end
    chk({nm, "_settle_cycles"}, n, 8);
  endtask

  task automatic ack_entry(input string nm, input bit last);
    cfg_ack = 1'b1;
    tick();
    cfg_ack = 1'b0;
    chk({nm, "_req_drop"}, int'(cfg_req), 0);
    if (!last) begin
      tick();
      chk({nm, "_req_next"}, int'(cfg_req), 1);
    end
  endtask

  task automatic wait_unmute(input string nm);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (amp_nmute) begin
        n = i;
        break;
      end
    end
    chk({nm, "_unmute_cycles"}, n, 4);
    chk({nm, "_run_state"}, int'(seq_state), 4);
  endtask

  initial begin
    tick();
    tick();
    resetb = 1'b1;
    chk("rst_state", int'(seq_state), 0);
    chk("rst_nenable", int'(amp_nenable), 1);
    chk("rst_nmute", int'(amp_nmute), 0);
    chk("rst_req", int'(cfg_req), 0);
    chk("rst_addr", int'(cfg_addr), 0);
    chk("rst_data", int'(cfg_data), 0);
    chk("rst_fault", int'(fault), 0);

    // Full power-up and lock loss
    audio_lock = 1'b1;
    push_wr(8'h02, 8'h00);
    push_wr(8'h03, 8'h1A);
    push_wr(8'h04, 8'h30);
    push_wr(8'h05, 8'h08);
    power_up("pu");
    chk("pu_cfg_state", int'(seq_state), 2);
    ack_entry("pu_e0", 0);
    ack_entry("pu_e1", 0);
    ack_entry("pu_e2", 0);
    ack_entry("pu_e3", 1);
    chk("pu_wait_state", int'(seq_state), 3);
    chk("pu_muted", int'(amp_nmute), 0);
    wait_unmute("pu");

    audio_lock = 1'b0;
    tick();
    audio_lock = 1'b1;
    chk("ll_nmute", int'(amp_nmute), 0);
    chk("ll_state", int'(seq_state), 3);
    wait_unmute("ll");

    // NACK on entry 2
    do_reset();
    push_wr(8'h02, 8'h00);
    push_wr(8'h03, 8'h1A);
    push_wr(8'h04, 8'h30);
`ifdef AMP_SEQ_RETRY_EN
    push_wr(8'h04, 8'h30);
    push_wr(8'h04, 8'h30);
    push_wr(8'h04, 8'h30);
    push_wr(8'h05, 8'h08);
`endif
    power_up("nk");
    ack_entry("nk_e0", 0);
    ack_entry("nk_e1", 0);
`ifdef AMP_SEQ_RETRY_EN
    for (int r = 0; r < 3; r++) begin
      cfg_nack = 1'b1;
      tick();
      cfg_nack = 1'b0;
      chk("nk_retry_drop", int'(cfg_req), 0);
      tick();
      chk("nk_retry_req", int'(cfg_req), 1);
    end
    ack_entry("nk_e2", 0);
    ack_entry("nk_e3", 1);
    chk("nk_fault", int'(fault), 0);
    chk("nk_state", int'(seq_state), 3);
`else
    cfg_nack = 1'b1;
    tick();
    cfg_nack = 1'b0;
    chk("nk_fault", int'(fault), 1);
    chk("nk_state", int'(seq_state), 6);
    chk("nk_nenable", int'(amp_nenable), 1);
    chk("nk_req", int'(cfg_req), 0);
    tick();
    chk("nk_hold_fault", int'(fault), 1);
    ena = 1'b0;
    tick();
    chk("nk_exit_state", int'(seq_state), 0);
    chk("nk_exit_fault", int'(fault), 0);
`endif

    // Shutdown while a request is outstanding
    do_reset();
    push_wr(8'h02, 8'h00);
    power_up("sd");
    ena = 1'b0;
    begin
      int held;
      held = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (cfg_req) held++;
      end
      chk("sd_req_held", held, 5);
    end
    cfg_ack = 1'b1;
    tick();
    cfg_ack = 1'b0;
    chk("sd_state", int'(seq_state), 5);
    chk("sd_req", int'(cfg_req), 0);
    chk("sd_nmute", int'(amp_nmute), 0);
    chk("sd_nenable_low", int'(amp_nenable), 0);
    begin
      int n;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (amp_nenable) begin
          n = i;
          break;
        end
      end
      chk("sd_mute_cycles", n, 4);
    end
    chk("sd_idle", int'(seq_state), 0);

    // Reset in the middle of the settle delay
    do_reset();
    ena = 1'b1;
    tick();
    tick();
    tick();
    chk("rp_pwrup", int'(seq_state), 1);
    resetb = 1'b0;
    tick();
    chk("rp_state", int'(seq_state), 0);
    chk("rp_nenable", int'(amp_nenable), 1);
    chk("rp_nmute", int'(amp_nmute), 0);
    chk("rp_req", int'(cfg_req), 0);
    chk("rp_fault", int'(fault), 0);
    resetb = 1'b1;
    push_wr(8'h02, 8'h00);
    power_up("rp");

    // Simultaneous ack and nack on entry 0
    do_reset();
    push_wr(8'h02, 8'h00);
    power_up("an");
    cfg_ack  = 1'b1;
    cfg_nack = 1'b1;
    tick();
    cfg_ack  = 1'b0;
    cfg_nack = 1'b0;
`ifdef AMP_SEQ_RETRY_EN
    chk("an_state", int'(seq_state), 2);
    chk("an_fault", int'(fault), 0);
`else
    chk("an_state", int'(seq_state), 6);
    chk("an_fault", int'(fault), 1);
`endif
    chk("an_req", int'(cfg_req), 0);

    do_reset();
    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
